// File: rtl/canvas_buffer.sv
// ============================================================================
// Module   : canvas_buffer
// Function : 160x120 paint canvas of 4-bit palette indices with a stamp/clear
//            sequencer and a 2-cycle palette read stage for the display.
//            Optional macro CANVAS_ROUND_BRUSH_EN selects a round brush.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module canvas_buffer #(
    parameter int COLS    = 160,
    parameter int ROWS    = 120,
    parameter int CELL_SH = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic [9:0] BrushX,
    input  logic [9:0] BrushY,
    input  logic [9:0] BrushS,
    input  logic [3:0] BrushColor,
    input  logic       PaintReq,
    input  logic       ClearReq,
    output logic       Busy,
    output logic       PaintDone,
    output logic [7:0] CanvasR,
    output logic [7:0] CanvasG,
    output logic [7:0] CanvasB
);

    localparam int c_AW    = $clog2(COLS * ROWS);
    localparam int c_XW    = $clog2(COLS);
    localparam int c_YW    = $clog2(ROWS);
    localparam int c_DEPTH = COLS * ROWS;

    localparam logic [1:0] c_ST_CLEAR = 2'd0;
    localparam logic [1:0] c_ST_IDLE  = 2'd1;
    localparam logic [1:0] c_ST_SETUP = 2'd2;
    localparam logic [1:0] c_ST_STAMP = 2'd3;

    localparam logic signed [11:0] c_XMAX = 12'(COLS - 1);
    localparam logic signed [11:0] c_YMAX = 12'(ROWS - 1);
    localparam logic [9:0]         c_XPIX = 10'(COLS << CELL_SH);
    localparam logic [9:0]         c_YPIX = 10'(ROWS << CELL_SH);

    logic [1:0]      r_state;
    logic [c_AW-1:0] r_addr;
    logic            r_done;
    logic [9:0]      r_bx, r_by, r_bs;
    logic [3:0]      r_col;
    logic [c_XW-1:0] r_x, r_x0, r_x1;
    logic [c_YW-1:0] r_y, r_y1;

    logic [3:0]      r_mem [0:c_DEPTH-1];
    logic [3:0]      r_rdata;
    logic            r_oob;
    logic [23:0]     r_rgb;

    // ---------------------------------------------------------------- bounds
    logic signed [11:0] w_xlo, w_xhi, w_ylo, w_yhi;
    logic signed [11:0] w_x0, w_x1, w_y0, w_y1;
    logic               w_empty;

    always_comb begin
        w_xlo = $signed({2'b00, r_bx}) - $signed({2'b00, r_bs});
        w_xhi = $signed({2'b00, r_bx}) + $signed({2'b00, r_bs});
        w_ylo = $signed({2'b00, r_by}) - $signed({2'b00, r_bs});
        w_yhi = $signed({2'b00, r_by}) + $signed({2'b00, r_bs});
        w_x0  = w_xlo[11] ? 12'sd0 : (w_xlo >>> CELL_SH);
        w_y0  = w_ylo[11] ? 12'sd0 : (w_ylo >>> CELL_SH);
        w_x1  = ((w_xhi >>> CELL_SH) > c_XMAX) ? c_XMAX : (w_xhi >>> CELL_SH);
        w_y1  = ((w_yhi >>> CELL_SH) > c_YMAX) ? c_YMAX : (w_yhi >>> CELL_SH);
        // A brush entirely past the right/bottom edge paints nothing.
        w_empty = (w_x0 > w_x1) || (w_y0 > w_y1);
    end

    // ------------------------------------------------------------ brush shape
    logic w_in_brush;
`ifdef CANVAS_ROUND_BRUSH_EN
    logic [11:0]        w_cx, w_cy;
    logic signed [25:0] w_dx, w_dy;
    logic [25:0]        w_dx2, w_dy2, w_r2;

    always_comb begin
        w_cx  = 12'((32'(r_x) << CELL_SH) + (32'(1) << (CELL_SH - 1)));
        w_cy  = 12'((32'(r_y) << CELL_SH) + (32'(1) << (CELL_SH - 1)));
        w_dx  = 26'($signed({1'b0, w_cx}) - $signed({3'b000, r_bx}));
        w_dy  = 26'($signed({1'b0, w_cy}) - $signed({3'b000, r_by}));
        w_dx2 = w_dx * w_dx;
        w_dy2 = w_dy * w_dy;
        w_r2  = {16'd0, r_bs} * {16'd0, r_bs};
        w_in_brush = (w_dx2 + w_dy2) <= w_r2;
    end
`else
    assign w_in_brush = 1'b1;
`endif

    // -------------------------------------------------------------- sequencer
    logic [c_AW-1:0] w_saddr;
    assign w_saddr = c_AW'(32'(r_y) * COLS + 32'(r_x));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= c_ST_CLEAR;
            r_addr  <= '0;
            r_done  <= 1'b0;
            r_bx    <= '0;
            r_by    <= '0;
            r_bs    <= '0;
            r_col   <= '0;
            r_x     <= '0;
            r_x0    <= '0;
            r_x1    <= '0;
            r_y     <= '0;
            r_y1    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_CLEAR: begin
                    if (r_addr == c_AW'(c_DEPTH - 1)) begin
                        r_state <= c_ST_IDLE;
                        r_done  <= 1'b1;
                    end else begin
                        r_addr <= r_addr + 1'b1;
                    end
                end
                c_ST_IDLE: begin
                    if (ClearReq) begin
                        r_state <= c_ST_CLEAR;
                        r_addr  <= '0;
                    end else if (PaintReq) begin
                        r_bx    <= BrushX;
                        r_by    <= BrushY;
                        r_bs    <= BrushS;
                        r_col   <= BrushColor;
                        r_state <= c_ST_SETUP;
                    end
                end
                c_ST_SETUP: begin
                    if (w_empty) begin
                        r_state <= c_ST_IDLE;
                        r_done  <= 1'b1;
                    end else begin
                        r_x0    <= w_x0[c_XW-1:0];
                        r_x1    <= w_x1[c_XW-1:0];
                        r_y1    <= w_y1[c_YW-1:0];
                        r_x     <= w_x0[c_XW-1:0];
                        r_y     <= w_y0[c_YW-1:0];
                        r_state <= c_ST_STAMP;
                    end
                end
                c_ST_STAMP: begin
                    if (r_x == r_x1) begin
                        r_x <= r_x0;
                        if (r_y == r_y1) begin
                            r_state <= c_ST_IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_y <= r_y + 1'b1;
                        end
                    end else begin
                        r_x <= r_x + 1'b1;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign Busy      = (r_state != c_ST_IDLE);
    assign PaintDone = r_done;

    // ------------------------------------------------------------ RAM ports
    logic            w_we;
    logic [c_AW-1:0] w_waddr;
    logic [3:0]      w_wdata;

    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_addr;
        w_wdata = 4'd0;
        if (r_state == c_ST_CLEAR) begin
            w_we = 1'b1;
        end else if (r_state == c_ST_STAMP) begin
            w_we    = w_in_brush;
            w_waddr = w_saddr;
            w_wdata = r_col;
        end
    end

    always_ff @(posedge Clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    logic            w_oob;
    logic [c_AW-1:0] w_raddr;
    assign w_oob   = (DrawX >= c_XPIX) || (DrawY >= c_YPIX);
    assign w_raddr = w_oob ? '0
                   : c_AW'(32'(DrawY >> CELL_SH) * COLS + 32'(DrawX >> CELL_SH));

    // Read-before-write: a same-address write this cycle returns the old cell.
    always_ff @(posedge Clk) begin
        r_rdata <= r_mem[w_raddr];
    end

    // -------------------------------------------------------------- palette
    function automatic logic [23:0] f_palette(input logic [3:0] idx);
        logic [7:0] g;
        g = {5'b00000, idx[2:0]} * 8'h24;
        case (idx)
            4'd0:    f_palette = 24'hFFFFFF;
            4'd1:    f_palette = 24'h000000;
            4'd2:    f_palette = 24'hFF0000;
            4'd3:    f_palette = 24'h00FF00;
            4'd4:    f_palette = 24'h0000FF;
            4'd5:    f_palette = 24'hFFFF00;
            4'd6:    f_palette = 24'h00FFFF;
            4'd7:    f_palette = 24'hFF00FF;
            default: f_palette = {g, g, g};
        endcase
    endfunction

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_oob <= 1'b0;
            r_rgb <= 24'h0;
        end else begin
            r_oob <= w_oob;
            r_rgb <= r_oob ? 24'h0 : f_palette(r_rdata);
        end
    end

    assign CanvasR = r_rgb[23:16];
    assign CanvasG = r_rgb[15:8];
    assign CanvasB = r_rgb[7:0];

endmodule

`default_nettype wire

// File: tb/tb_canvas_buffer.sv
// ============================================================================
// Module   : tb_canvas_buffer
// Function : Randomized scoreboard bench for canvas_buffer against a cell-array
//            reference model (honours CANVAS_ROUND_BRUSH_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_canvas_buffer;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [9:0] DrawX = '0, DrawY = '0;
    logic [9:0] BrushX = '0, BrushY = '0, BrushS = '0;
    logic [3:0] BrushColor = '0;
    logic       PaintReq = 1'b0, ClearReq = 1'b0;
    logic       Busy, PaintDone;
    logic [7:0] CanvasR, CanvasG, CanvasB;

    canvas_buffer dut (
        .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
        .BrushX(BrushX), .BrushY(BrushY), .BrushS(BrushS), .BrushColor(BrushColor),
        .PaintReq(PaintReq), .ClearReq(ClearReq), .Busy(Busy), .PaintDone(PaintDone),
        .CanvasR(CanvasR), .CanvasG(CanvasG), .CanvasB(CanvasB)
    );

    always #5 Clk = ~Clk;

    int          checks = 0;
    int          failures = 0;
    logic [3:0]  model [0:19199];
    logic [23:0] exp_q [$];
    int          done_q [$];
    logic        rd_issue = 1'b0, p1 = 1'b0, p2 = 1'b0;
    int          busy_cnt = 0;

    function automatic logic [23:0] pal(input int idx);
        logic [23:0] tbl [0:7];
        int g;
        tbl = '{24'hFFFFFF, 24'h000000, 24'hFF0000, 24'h00FF00,
                24'h0000FF, 24'hFFFF00, 24'h00FFFF, 24'hFF00FF};
        if (idx < 8) return tbl[idx];
        g = (idx - 8) * 36;
        return {g[7:0], g[7:0], g[7:0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Read-pipeline tracker and monitor
    always @(posedge Clk) begin
        if (Reset) begin
            p1 <= 1'b0;
            p2 <= 1'b0;
        end else begin
            p1 <= rd_issue;
            p2 <= p1;
        end
    end

    always @(negedge Clk) begin
        if (Reset) begin
            busy_cnt = 0;
        end else begin
            if (p2) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL pixel_unexpected: got %h expected none", {CanvasR, CanvasG, CanvasB});
                end else begin
                    chk("pixel_rgb", {8'h0, CanvasR, CanvasG, CanvasB}, {8'h0, exp_q.pop_front()});
                end
            end
            if (Busy) busy_cnt++;
            if (PaintDone) begin
                if (done_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL paintdone_unexpected: got pulse expected none");
                end else begin
                    chk("busy_cycles", busy_cnt, done_q.pop_front());
                end
                chk("busy_low_at_done", {31'd0, Busy}, 32'd0);
                busy_cnt = 0;
            end
        end
    end

    task automatic model_clear();
        for (int i = 0; i < 19200; i++) model[i] = 4'd0;
    endtask

    task automatic read_px(input int x, input int y);
        @(posedge Clk); #1;
        DrawX = 10'(x);
        DrawY = 10'(y);
        rd_issue = 1'b1;
        if (x >= 640 || y >= 480) exp_q.push_back(24'h0);
        else exp_q.push_back(pal(int'(model[(y / 4) * 160 + x / 4])));
        @(posedge Clk); #1;
        rd_issue = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_q.size() != 0 && n < budget) begin
            @(posedge Clk);
            n++;
        end
        if (done_q.size() != 0) begin
            checks++; failures++;
            $display("FAIL done_timeout: got no PaintDone expected one within %0d cycles", budget);
            done_q.delete();
        end
        repeat (3) @(posedge Clk);
    endtask

    // Model: bounding box of cells touched by the brush square, clamped to canvas.
    task automatic stamp(input int bx, input int by, input int s, input int col);
        int x0, x1, y0, y1, n, dx, dy;
        x0 = (bx - s < 0) ? 0 : (bx - s) / 4;
        y0 = (by - s < 0) ? 0 : (by - s) / 4;
        x1 = ((bx + s) / 4 > 159) ? 159 : (bx + s) / 4;
        y1 = ((by + s) / 4 > 119) ? 119 : (by + s) / 4;
        n  = (x1 - x0 + 1) * (y1 - y0 + 1);
        for (int y = y0; y <= y1; y++) begin
            for (int x = x0; x <= x1; x++) begin
                dx = x * 4 + 2 - bx;
                dy = y * 4 + 2 - by;
`ifdef CANVAS_ROUND_BRUSH_EN
                if (dx * dx + dy * dy <= s * s) model[y * 160 + x] = 4'(col);
`else
                if (dx == dx && dy == dy) model[y * 160 + x] = 4'(col);
`endif
            end
        end
        done_q.push_back(n + 1);
        @(posedge Clk); #1;
        BrushX = 10'(bx); BrushY = 10'(by); BrushS = 10'(s); BrushColor = 4'(col);
        PaintReq = 1'b1;
        @(posedge Clk); #1;
        PaintReq = 1'b0;
        wait_done(2000);
    endtask

    initial begin
        int bx, by, s;
        model_clear();
        Reset = 1'b1;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("reset_busy", {31'd0, Busy}, 32'd1);
        chk("reset_paintdone", {31'd0, PaintDone}, 32'd0);
        chk("reset_rgb", {8'h0, CanvasR, CanvasG, CanvasB}, 32'h0);

        done_q.push_back(19200);
        @(posedge Clk); #1;
        Reset = 1'b0;
        wait_done(20000);

        read_px(0, 0);
        read_px(700, 0);
        read_px(639, 479);
        read_px(0, 480);

        stamp(100, 100, 4, 2);
        read_px(96, 96);
        read_px(107, 107);
        read_px(108, 100);
        read_px(95, 100);

        stamp(2, 2, 10, 4);
        read_px(0, 0);
        read_px(16, 0);
        read_px(15, 15);

        stamp(200, 200, 8, 1);
        read_px(192, 192);
        read_px(200, 200);
        read_px(212, 200);

        for (int it = 0; it < 15; it++) begin
            bx = int'($urandom_range(0, 639));
            by = int'($urandom_range(0, 479));
            s  = int'($urandom_range(0, 24));
            stamp(bx, by, s, int'($urandom_range(0, 15)));
            read_px(bx, by);
            read_px((bx + s > 639) ? 639 : bx + s, by);
            read_px(bx, (by - s < 0) ? 0 : by - s);
            read_px(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)));
        end

        // Clear wins over a simultaneous paint; paint during busy is ignored.
        done_q.push_back(19200);
        @(posedge Clk); #1;
        BrushX = 10'd320; BrushY = 10'd240; BrushS = 10'd30; BrushColor = 4'd3;
        ClearReq = 1'b1; PaintReq = 1'b1;
        @(posedge Clk); #1;
        ClearReq = 1'b0; PaintReq = 1'b0;
        model_clear();
        repeat (50) @(posedge Clk);
        #1 PaintReq = 1'b1;
        @(posedge Clk); #1 PaintReq = 1'b0;
        wait_done(20000);
        repeat (10) @(posedge Clk);
        read_px(320, 240);
        read_px(100, 100);
        read_px(0, 0);

        // Reset mid-stamp aborts and restarts the full clear.
        @(posedge Clk); #1;
        BrushX = 10'd300; BrushY = 10'd200; BrushS = 10'd40; BrushColor = 4'd6;
        PaintReq = 1'b1;
        @(posedge Clk); #1 PaintReq = 1'b0;
        repeat (5) @(posedge Clk);
        #1 Reset = 1'b1;
        @(negedge Clk);
        chk("midstamp_reset_busy", {31'd0, Busy}, 32'd1);
        model_clear();
        repeat (2) @(posedge Clk);
        done_q.push_back(19200);
        #1 Reset = 1'b0;
        wait_done(20000);
        read_px(300, 200);
        read_px(290, 210);
        read_px(700, 100);
        for (int i = 0; i < 4; i++)
            read_px(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)));

        repeat (5) @(posedge Clk);
        chk("scoreboard_drained", exp_q.size() + done_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
